fixed_mul_seq: RTL and testbench
================================

# fixed_mul_seq

Iterative, parametrised signed fixed-point multiplier for the audio datapath. It uses one shift-add step per clock and a valid/ready handshake on both sides. It supersedes the combinational fractional multiplier in gain, mix and filter-coefficient stages where timing closure matters more than latency. It adds signed operands, a selectable rounding mode, saturation with an overflow flag, and back-pressure.

## Interface
Parameters:
- `WIDTH`, 24: total operand/result width, two's complement (>= 4).
- `FRAC`, 12: fractional bits, Q(WIDTH-FRAC).FRAC (1 <= FRAC < WIDTH).
- `ROUND`, 1: 0 = truncate magnitude; 1 = round half away from zero.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = wrap (keep low WIDTH bits).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block idle, will accept.
- `a`  in  WIDTH  signed multiplicand.
- `b`  in  WIDTH  signed multiplier.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `c`  out  WIDTH  signed product, same Q format.
- `ovf`  out  1  result overflowed (saturated or wrapped); qualified by `out_valid`.

## Operation
- Reset values: state IDLE, `out_valid`=0, `c`=0, `ovf`=0. `in_ready`=0 while `rst`=1.
- `in_ready` = (state==IDLE) && !rst.
- IDLE: on `in_valid && in_ready`, latch the following and go to CALC:
  - |a| and |b| as WIDTH+1-bit unsigned values, so -2^(WIDTH-1) is exact.
  - sign = a[MSB]^b[MSB].
  - cnt=0, 2*WIDTH+2-bit accumulator = 0.
- CALC: each cycle, if |b|[cnt], acc += |a|<<cnt. cnt++. When cnt==WIDTH-1 is processed, go to NORM.
- NORM (one cycle), then go to DONE with `out_valid`=1:
  - mag = (acc + (ROUND ? 2^(FRAC-1) : 0)) >> FRAC.
  - res = sign ? -mag : mag.
  - Overflow: res outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Then `ovf`=1, and `c` = clamp when SATURATE, else res[WIDTH-1:0].
  - A zero product with sign=1 yields `c`=0. There is no negative zero.
- DONE: `c`/`ovf` held stable while `out_ready`=0. On `out_valid && out_ready`, go to IDLE and clear `out_valid`. `c` retains its last value.
- `in_valid` is ignored outside IDLE. `a`/`b` may change freely after acceptance.
- `rst` in any state aborts the operation and forces the reset values on the next edge. No partial result is emitted.

## Timing
- Operand accepted at edge k → `out_valid` rises at edge k+WIDTH+1. Latency is WIDTH+1 cycles (25 at default).
- Throughput with `out_ready` held high: one result per WIDTH+3 cycles.
  - Handshake edge → IDLE.
  - `in_ready` high in the following cycle.
- No combinational path from inputs to `in_ready`/`out_valid`, except `rst` → `in_ready`.
- `c`, `ovf`, `out_valid` are registered outputs.

## Structure
- Shared package `fixed_pkg`:
  - state enum (IDLE, CALC, NORM, DONE).
  - round-mode constants `RND_TRUNC`, `RND_HALF_AWAY`.
  - function `fixed_max(width)`/`fixed_min(width)` returning saturation limits.
- One sub-module: `fixed_saturate` (combinational). Input: signed wide value, WIDTH, SATURATE. Outputs: narrowed value and ovf flag. It is instantiated in NORM and reusable by adders downstream.
- Counter width $clog2(WIDTH). The accumulator is not resized per parameter beyond 2*WIDTH+2.

## Test plan
All at defaults (WIDTH=24, FRAC=12, ROUND=1, SATURATE=1) unless noted.
- Basic: a=0x001800 (1.5), b=0x002000 (2.0), `out_ready`=1 → `c`=0x003000, `ovf`=0, `out_valid` exactly 25 cycles after accept.
- Sign:
  - a=0xFFE800 (-1.5), b=0x002000 → `c`=0xFFD000.
  - a=0x800000 (-2048.0), b=0x001000 (1.0) → `c`=0x800000, `ovf`=0.
- Rounding: a=0x000001, b=0x000800 → `c`=0x000001. With ROUND=0 → `c`=0x000000. Negate a → 0xFFFFFF / 0x000000.
- Saturation: a=b=0x7FFFFF → `c`=0x7FFFFF, `ovf`=1. a=0x7FFFFF, b=0x800000 → `c`=0x800000, `ovf`=1. With SATURATE=0 → `c` = low 24 bits of the true product, `ovf`=1.
- Back-pressure: hold `out_ready`=0 for 10 cycles after `out_valid`, and drive `in_valid`=1 with new operands. Required: `c` stable, `in_ready`=0, new operands not taken. Release → handshake, then the second operation is accepted the cycle after.
- Reset mid-CALC: assert `rst` at cnt=7 for 1 cycle. Required: next cycle state IDLE, `out_valid`=0, `c`=0. The following operation 0x001000×0x001000 → 0x001000.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: multiplier FSM states, rounding modes and
// saturation limits for any two's-complement width up to FIX_LIM_W bits.
package fixed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int RND_TRUNC     = 0;
    localparam int RND_HALF_AWAY = 1;

    // Limits are computed at this width and then narrowed by the caller.
    localparam int FIX_LIM_W = 128;

    // Largest positive value of a width-bit two's-complement number.
    function automatic logic signed [FIX_LIM_W-1:0] fixed_max(input int width);
        fixed_max = (FIX_LIM_W'(1) << (width - 1)) - FIX_LIM_W'(1);
    endfunction

    // Most negative value of a width-bit two's-complement number.
    function automatic logic signed [FIX_LIM_W-1:0] fixed_min(input int width);
        fixed_min = ~fixed_max(width);
    endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Narrows a wide signed value to WIDTH bits. Flags overflow when the value
// does not fit, and either clamps to the nearest limit or keeps the low bits.
module fixed_saturate
    import fixed_pkg::*;
#(
    parameter int IN_W     = 51,
    parameter int WIDTH    = 24,
    parameter int SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    localparam logic signed [FIX_LIM_W-1:0] MAX_V = fixed_max(WIDTH);
    localparam logic signed [FIX_LIM_W-1:0] MIN_V = fixed_min(WIDTH);

    // Sign bit of the narrowed value plus every bit above it.
    logic [IN_W-WIDTH:0] top_bits;

    // The value fits only when all bits from WIDTH-1 upward are copies of the sign.
    always_comb begin
        top_bits = value[IN_W-1:WIDTH-1];
        ovf      = !((&top_bits) || !(|top_bits));
        result   = value[WIDTH-1:0];
        if (ovf && (SATURATE != 0)) begin
            result = value[IN_W-1] ? MIN_V[WIDTH-1:0] : MAX_V[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fixed_mul_seq.sv
// Iterative signed fixed-point multiplier, one shift-add step per clock.
// Operands are converted to sign + magnitude on acceptance so the most
// negative value is exact; the sign is reapplied after rounding so rounding
// is symmetric (half away from zero) and there is no negative zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and never while rst is high;
// out_valid stays high with c/ovf frozen until out_ready is seen.
module fixed_mul_seq
    import fixed_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int FRAC     = 12,
    parameter int ROUND    = RND_HALF_AWAY,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] c,
    output logic                    ovf,
    output state_t                  dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int MAG_W = WIDTH + 1;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int RES_W = ACC_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ACC_W-1:0] RND_ADD  =
        (ROUND != RND_TRUNC) ? (ACC_W'(1) << (FRAC - 1)) : ACC_W'(0);

    state_t             state;
    logic [MAG_W-1:0]   abs_a;
    logic [MAG_W-1:0]   abs_b;
    logic               sign_q;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;

    logic [MAG_W-1:0]   a_ext;
    logic [MAG_W-1:0]   b_ext;
    logic [MAG_W-1:0]   abs_a_in;
    logic [MAG_W-1:0]   abs_b_in;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W-1:0]   rounded;
    logic [ACC_W-1:0]   mag;
    logic [RES_W-1:0]   mag_ext;
    logic [RES_W-1:0]   res;
    logic [WIDTH-1:0]   sat_c;
    logic               sat_ovf;

    assign in_ready  = (state == IDLE) && !rst;
    assign dbg_state = state;

    // Magnitudes one bit wider than the operands so -2^(WIDTH-1) stays exact.
    assign a_ext    = {a[WIDTH-1], a};
    assign b_ext    = {b[WIDTH-1], b};
    assign abs_a_in = a[WIDTH-1] ? (~a_ext + MAG_W'(1)) : a_ext;
    assign abs_b_in = b[WIDTH-1] ? (~b_ext + MAG_W'(1)) : b_ext;

    // One partial product per cycle, selected by the current multiplier bit.
    assign addend   = ACC_W'(abs_a) << cnt;
    assign acc_next = abs_b[cnt] ? (acc + addend) : acc;

    // Round the magnitude, drop the fractional bits, then reapply the sign.
    assign rounded = acc + RND_ADD;
    assign mag     = rounded >> FRAC;
    assign mag_ext = {1'b0, mag};
    assign res     = sign_q ? (~mag_ext + RES_W'(1)) : mag_ext;

    fixed_saturate #(
        .IN_W     (RES_W),
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_sat (
        .value  (res),
        .result (sat_c),
        .ovf    (sat_ovf)
    );

    // Control FSM with the datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
            abs_a     <= '0;
            abs_b     <= '0;
            sign_q    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        abs_a  <= abs_a_in;
                        abs_b  <= abs_b_in;
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        cnt    <= '0;
                        acc    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    c         <= sat_c;
                    ovf       <= sat_ovf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Bench for fixed_mul_seq. Three instances share one set of inputs:
// defaults, truncating, and wrapping. Results come from an integer model.
module tb_fixed_mul_seq;
    import fixed_pkg::*;

    localparam int  W      = 24;
    localparam int  FRAC   = 12;
    localparam int  LAT    = W + 1;
    localparam int  PERIOD = W + 3;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready_d  [3];
    logic         out_valid_d [3];
    logic [W-1:0] c_d         [3];
    logic         ovf_d       [3];
    state_t       dbg_d       [3];

    bit rnd_cfg [3] = '{1'b1, 1'b0, 1'b1};
    bit sat_cfg [3] = '{1'b1, 1'b1, 1'b0};

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int           got_wait;
    int           got_lat;
    int           acc_cyc;
    logic [W-1:0] got_c   [3];
    logic         got_ovf [3];

    fixed_mul_seq #(.WIDTH(W), .FRAC(FRAC), .ROUND(1), .SATURATE(1)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .a(a), .b(b), .out_valid(out_valid_d[0]), .out_ready(out_ready),
        .c(c_d[0]), .ovf(ovf_d[0]), .dbg_state(dbg_d[0]));

    fixed_mul_seq #(.WIDTH(W), .FRAC(FRAC), .ROUND(0), .SATURATE(1)) u_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .a(a), .b(b), .out_valid(out_valid_d[1]), .out_ready(out_ready),
        .c(c_d[1]), .ovf(ovf_d[1]), .dbg_state(dbg_d[1]));

    fixed_mul_seq #(.WIDTH(W), .FRAC(FRAC), .ROUND(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .a(a), .b(b), .out_valid(out_valid_d[2]), .out_ready(out_ready),
        .c(c_d[2]), .ovf(ovf_d[2]), .dbg_state(dbg_d[2]));

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer product, magnitude rounding, sign, then limit.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input bit rnd, input bit sat,
                                  output logic [W-1:0] mc, output logic movf);
        longint pa, pb, p, m, mag, res, lim;
        bit     neg;
        pa   = longint'($signed(ma));
        pb   = longint'($signed(mb));
        p    = pa * pb;
        neg  = (p < 0);
        m    = neg ? -p : p;
        mag  = (m + (rnd ? (longint'(1) << (FRAC - 1)) : longint'(0))) >> FRAC;
        res  = neg ? -mag : mag;
        movf = (res > MAXV) || (res < MINV);
        lim  = (res > 0) ? MAXV : MINV;
        mc   = (movf && sat) ? lim[W-1:0] : res[W-1:0];
    endfunction

    // Driver: present operands, wait for acceptance and result, then consume it.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        int t;
        a = op_a; b = op_b; in_valid = 1'b1; out_ready = 1'b1;
        t = 0;
        while (!in_ready_d[0] && t < 100) begin @(posedge clk); #1; t++; end
        got_wait = t;
        if (!in_ready_d[0]) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: in_ready still %b after %0d cycles, want 1", in_ready_d[0], t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        t = 0;
        while (!out_valid_d[0] && t < 100) begin @(posedge clk); #1; t++; end
        got_lat = t;
        if (!out_valid_d[0]) begin
            n_checks++; n_err++;
            $display("FAIL result_timeout: out_valid still %b after %0d cycles, want 1", out_valid_d[0], t);
            return;
        end
        for (int k = 0; k < 3; k++) begin
            got_c[k]   = c_d[k];
            got_ovf[k] = ovf_d[k];
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready_d[k] !== 1'b0 || out_valid_d[k] !== 1'b0 || c_d[k] !== '0 ||
                ovf_d[k] !== 1'b0 || dbg_d[k] !== IDLE) begin
                n_err++;
                $display("FAIL reset_values dut%0d: in_ready=%b out_valid=%b c=%h ovf=%b state=%0d, want 0 0 000000 0 0",
                         k, in_ready_d[k], out_valid_d[k], c_d[k], ovf_d[k], dbg_d[k]);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_d[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b, want 1", in_ready_d[0]);
        end
    endtask

    // Directed vectors; expected values for the default instance are fixed constants.
    task automatic test_directed();
        logic [W-1:0] ta   [11] = '{24'h001800, 24'hFFE800, 24'h800000, 24'h000001, 24'hFFFFFF,
                                    24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h000000, 24'hFFFFFF, 24'h001000};
        logic [W-1:0] tb_v [11] = '{24'h002000, 24'h002000, 24'h001000, 24'h000800, 24'h000800,
                                    24'h7FFFFF, 24'h800000, 24'h800000, 24'h800000, 24'h000001, 24'hFFF000};
        logic [W-1:0] te_c [11] = '{24'h003000, 24'hFFD000, 24'h800000, 24'h000001, 24'hFFFFFF,
                                    24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h000000, 24'h000000, 24'hFFF000};
        logic         te_o [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] mc;
        logic         mo;
        for (int i = 0; i < 11; i++) begin
            run_op(ta[i], tb_v[i]);
            n_checks++;
            if (got_lat !== LAT) begin
                n_err++;
                $display("FAIL latency vec%0d: got %0d cycles, want %0d", i, got_lat, LAT);
            end
            n_checks++;
            if (got_c[0] !== te_c[i] || got_ovf[0] !== te_o[i]) begin
                n_err++;
                $display("FAIL directed vec%0d dut0 %h*%h: got c=%h ovf=%b, want c=%h ovf=%b",
                         i, ta[i], tb_v[i], got_c[0], got_ovf[0], te_c[i], te_o[i]);
            end
            for (int k = 1; k < 3; k++) begin
                model(ta[i], tb_v[i], rnd_cfg[k], sat_cfg[k], mc, mo);
                n_checks++;
                if (got_c[k] !== mc || got_ovf[k] !== mo) begin
                    n_err++;
                    $display("FAIL directed vec%0d dut%0d %h*%h: got c=%h ovf=%b, want c=%h ovf=%b",
                             i, k, ta[i], tb_v[i], got_c[k], got_ovf[k], mc, mo);
                end
            end
            n_checks++;
            if (out_valid_d[0] !== 1'b0 || in_ready_d[0] !== 1'b1 || c_d[0] !== got_c[0]) begin
                n_err++;
                $display("FAIL after_handshake vec%0d: out_valid=%b in_ready=%b c=%h, want 0 1 %h",
                         i, out_valid_d[0], in_ready_d[0], c_d[0], got_c[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev_acc;
        logic [W-1:0] ra, rb, mc;
        logic mo;
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 32'h0000FFFF));
            run_op(ra, rb);
            if (prev_acc >= 0) begin
                n_checks++;
                if (acc_cyc - prev_acc !== PERIOD) begin
                    n_err++;
                    $display("FAIL throughput op%0d: accept spacing %0d cycles, want %0d",
                             i, acc_cyc - prev_acc, PERIOD);
                end
            end
            prev_acc = acc_cyc;
            model(ra, rb, rnd_cfg[0], sat_cfg[0], mc, mo);
            n_checks++;
            if (got_c[0] !== mc || got_ovf[0] !== mo) begin
                n_err++;
                $display("FAIL back_to_back op%0d %h*%h: got c=%h ovf=%b, want c=%h ovf=%b",
                         i, ra, rb, got_c[0], got_ovf[0], mc, mo);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] op1, op2, op3, op4, held, mc;
        logic mo;
        int t;
        op1 = 24'h003400; op2 = 24'hFFE000; op3 = 24'h000C00; op4 = 24'h002800;
        out_ready = 1'b0; a = op1; b = op2; in_valid = 1'b1;
        t = 0;
        while (!in_ready_d[0] && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        a = op3; b = op4;
        t = 0;
        while (!out_valid_d[0] && t < 100) begin @(posedge clk); #1; t++; end
        n_checks++;
        if (out_valid_d[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_result_timeout: out_valid=%b after %0d cycles, want 1", out_valid_d[0], t);
        end
        held = c_d[0];
        model(op1, op2, rnd_cfg[0], sat_cfg[0], mc, mo);
        n_checks++;
        if (held !== mc || ovf_d[0] !== mo) begin
            n_err++;
            $display("FAIL bp_first_result: got c=%h ovf=%b, want c=%h ovf=%b", held, ovf_d[0], mc, mo);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (c_d[0] !== held || out_valid_d[0] !== 1'b1 || in_ready_d[0] !== 1'b0 || dbg_d[0] !== DONE) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: c=%h out_valid=%b in_ready=%b state=%0d, want %h 1 0 3",
                         i, c_d[0], out_valid_d[0], in_ready_d[0], dbg_d[0], held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0 || in_ready_d[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid_d[0], in_ready_d[0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dbg_d[0] !== CALC || in_ready_d[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_second_accept: state=%0d in_ready=%b, want 1 0", dbg_d[0], in_ready_d[0]);
        end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid_d[0] && t < 100) begin @(posedge clk); #1; t++; end
        for (int k = 0; k < 3; k++) begin
            model(op3, op4, rnd_cfg[k], sat_cfg[k], mc, mo);
            n_checks++;
            if (c_d[k] !== mc || ovf_d[k] !== mo || out_valid_d[k] !== 1'b1) begin
                n_err++;
                $display("FAIL bp_second_result dut%0d: c=%h ovf=%b valid=%b, want c=%h ovf=%b valid=1",
                         k, c_d[k], ovf_d[k], out_valid_d[k], mc, mo);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int t;
        out_ready = 1'b1; a = 24'h123456; b = 24'h054321; in_valid = 1'b1;
        t = 0;
        while (!in_ready_d[0] && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready_d[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_in_ready: in_ready=%b while rst high, want 0", in_ready_d[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dbg_d[k] !== IDLE || out_valid_d[k] !== 1'b0 || c_d[k] !== '0 || ovf_d[k] !== 1'b0) begin
                n_err++;
                $display("FAIL rst_abort dut%0d: state=%0d out_valid=%b c=%h ovf=%b, want 0 0 000000 0",
                         k, dbg_d[k], out_valid_d[k], c_d[k], ovf_d[k]);
            end
        end
        run_op(24'h001000, 24'h001000);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (got_c[k] !== 24'h001000 || got_ovf[k] !== 1'b0) begin
                n_err++;
                $display("FAIL rst_next_op dut%0d: got c=%h ovf=%b, want c=001000 ovf=0",
                         k, got_c[k], got_ovf[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, mc;
        logic mo;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case (i % 4)
                0:       rb = W'($urandom_range(0, 32'h00003FFF));
                1:       rb = W'(-$urandom_range(1, 32'h00003FFF));
                2:       rb = W'($urandom_range(0, 32'h00000FFF));
                default: rb = W'($urandom);
            endcase
            if (i % 5 == 0) ra = W'($urandom_range(0, 32'h00000FFF));
            run_op(ra, rb);
            n_checks++;
            if (got_lat !== LAT) begin
                n_err++;
                $display("FAIL rand_latency op%0d: got %0d, want %0d", i, got_lat, LAT);
            end
            for (int k = 0; k < 3; k++) begin
                model(ra, rb, rnd_cfg[k], sat_cfg[k], mc, mo);
                n_checks++;
                if (got_c[k] !== mc || got_ovf[k] !== mo) begin
                    n_err++;
                    $display("FAIL random op%0d dut%0d %h*%h: got c=%h ovf=%b, want c=%h ovf=%b",
                             i, k, ra, rb, got_c[k], got_ovf[k], mc, mo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
